// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU operand-issue / write-back unit.
package alu_issue_pkg;

    // Instruction field layout: [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm
    localparam int unsigned InstrWidth = 32;
    localparam int unsigned FieldWidth = 8;
    localparam int unsigned OpcodeLsb  = 24;
    localparam int unsigned DestLsb    = 16;
    localparam int unsigned Src1Lsb    = 8;
    localparam int unsigned Src2Lsb    = 0;

    localparam logic [7:0] OpLoadi = 8'h00;
    localparam logic [7:0] OpMov   = 8'h01;
    localparam logic [7:0] OpAdd   = 8'h02;
    localparam logic [7:0] OpSub   = 8'h03;
    localparam logic [7:0] OpAnd   = 8'h04;
    localparam logic [7:0] OpOr    = 8'h05;
    localparam logic [7:0] OpJ     = 8'h06;
    localparam logic [7:0] OpBeq   = 8'h07;

    typedef enum logic [2:0] {
        AluFwd = 3'b000,
        AluAdd = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011
    } alu_sel_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StExec = 1'b1
    } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake, ALU operand/result and retire signals of the issue unit.
interface alu_issue_if #(
    parameter int unsigned DataWidth = 8
);
    logic                 instr_valid;
    logic                 instr_ready;
    logic [31:0]          instruction;
    logic [DataWidth-1:0] alu_data1;
    logic [DataWidth-1:0] alu_data2;
    logic [2:0]           alu_select;
    logic [DataWidth-1:0] alu_result;
    logic                 alu_zero;
    logic                 done;
    logic                 branch_taken;
    logic [7:0]           branch_offset;
    logic                 illegal;

    // Environment side: instruction fetch plus the ALU itself.
    modport master (
        output instr_valid, instruction, alu_result, alu_zero,
        input  instr_ready, alu_data1, alu_data2, alu_select,
        input  done, branch_taken, branch_offset, illegal
    );

    modport slave (
        input  instr_valid, instruction, alu_result, alu_zero,
        output instr_ready, alu_data1, alu_data2, alu_select,
        output done, branch_taken, branch_offset, illegal
    );
endinterface

// File: rtl/alu_issue_regfile.sv
// General-purpose register file: two combinational reads, one synchronous write, sync clear.
// Optional debug read port enabled by ALU_ISSUE_DBG_EN.
module alu_issue_regfile #(
    parameter  int unsigned RegCount  = 8,
    parameter  int unsigned DataWidth = 8,
    localparam int unsigned AddrWidth = (RegCount > 1) ? $clog2(RegCount) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [AddrWidth-1:0] rd_addr1_i,
    output logic [DataWidth-1:0] rd_data1_o,
    input  logic [AddrWidth-1:0] rd_addr2_i,
    output logic [DataWidth-1:0] rd_data2_o,
`ifdef ALU_ISSUE_DBG_EN
    input  logic [AddrWidth-1:0] dbg_addr_i,
    output logic [DataWidth-1:0] dbg_data_o,
`endif
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i
);

    logic [DataWidth-1:0] regs_q [RegCount];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(RegCount); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_data1_o = regs_q[rd_addr1_i];
    assign rd_data2_o = regs_q[rd_addr2_i];

`ifdef ALU_ISSUE_DBG_EN
    // Reads the array directly, so the write cycle still shows the old value.
    assign dbg_data_o = regs_q[dbg_addr_i];
`endif

endmodule

// File: rtl/alu_issue_unit.sv
// Operand-issue and write-back front end for the 8-bit ALU; owns the register file.
// Define ALU_ISSUE_DBG_EN to add the dbg_addr_i/dbg_data_o register read port.
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter  int unsigned RegCount  = 8,
    parameter  int unsigned DataWidth = 8,
    localparam int unsigned AddrWidth = (RegCount > 1) ? $clog2(RegCount) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
`ifdef ALU_ISSUE_DBG_EN
    input  logic [AddrWidth-1:0] dbg_addr_i,
    output logic [DataWidth-1:0] dbg_data_o,
`endif
    alu_issue_if.slave           bus
);

    logic [7:0]           opcode;
    logic [7:0]           dest_field;
    logic [7:0]           src1_field;
    logic [7:0]           src2_field;
    logic [AddrWidth-1:0] rd_addr1;
    logic [AddrWidth-1:0] rd_addr2;
    logic [DataWidth-1:0] rd_data1;
    logic [DataWidth-1:0] rd_data2;
    logic [DataWidth-1:0] imm;

    assign opcode     = bus.instruction[OpcodeLsb +: FieldWidth];
    assign dest_field = bus.instruction[DestLsb +: FieldWidth];
    assign src1_field = bus.instruction[Src1Lsb +: FieldWidth];
    assign src2_field = bus.instruction[Src2Lsb +: FieldWidth];
    assign rd_addr1   = src1_field[AddrWidth-1:0];
    assign rd_addr2   = src2_field[AddrWidth-1:0];
    assign imm        = DataWidth'(src2_field);

    // Register fields above the index width are don't-care.
    logic unused_src1_hi;
    assign unused_src1_hi = ^src1_field[7:AddrWidth];

    // Decoded operands and retire behaviour of the presented instruction
    logic [DataWidth-1:0] dec_data1;
    logic [DataWidth-1:0] dec_data2;
    alu_sel_e             dec_sel;
    logic                 dec_write;
    logic                 dec_jump;
    logic                 dec_beq;
    logic                 dec_illegal;

    always_comb begin
        dec_data1   = '0;
        dec_data2   = '0;
        dec_sel     = AluFwd;
        dec_write   = 1'b0;
        dec_jump    = 1'b0;
        dec_beq     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OpLoadi: begin
                dec_data2 = imm;
                dec_write = 1'b1;
            end
            OpMov: begin
                dec_data2 = rd_data2;
                dec_write = 1'b1;
            end
            OpAdd: begin
                dec_data1 = rd_data1;
                dec_data2 = rd_data2;
                dec_sel   = AluAdd;
                dec_write = 1'b1;
            end
            OpSub: begin
                dec_data1 = rd_data1;
                dec_data2 = '0 - rd_data2;
                dec_sel   = AluAdd;
                dec_write = 1'b1;
            end
            OpAnd: begin
                dec_data1 = rd_data1;
                dec_data2 = rd_data2;
                dec_sel   = AluAnd;
                dec_write = 1'b1;
            end
            OpOr: begin
                dec_data1 = rd_data1;
                dec_data2 = rd_data2;
                dec_sel   = AluOr;
                dec_write = 1'b1;
            end
            OpJ: begin
                dec_jump = 1'b1;
            end
            OpBeq: begin
                // Equality test through the ALU: a + (-b) is zero exactly when a == b.
                dec_data1 = rd_data1;
                dec_data2 = '0 - rd_data2;
                dec_sel   = AluAdd;
                dec_beq   = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    state_e               state_q;
    logic [DataWidth-1:0] data1_q;
    logic [DataWidth-1:0] data2_q;
    alu_sel_e             sel_q;
    logic [AddrWidth-1:0] dest_q;
    logic [7:0]           offset_q;
    logic                 write_q;
    logic                 jump_q;
    logic                 beq_q;
    logic                 illegal_pend_q;
    logic                 done_q;
    logic                 branch_taken_q;
    logic [7:0]           branch_offset_q;
    logic                 illegal_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= StIdle;
            data1_q         <= '0;
            data2_q         <= '0;
            sel_q           <= AluFwd;
            dest_q          <= '0;
            offset_q        <= '0;
            write_q         <= 1'b0;
            jump_q          <= 1'b0;
            beq_q           <= 1'b0;
            illegal_pend_q  <= 1'b0;
            done_q          <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_offset_q <= '0;
            illegal_q       <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.instr_valid) begin
                        data1_q        <= dec_data1;
                        data2_q        <= dec_data2;
                        sel_q          <= dec_sel;
                        dest_q         <= dest_field[AddrWidth-1:0];
                        offset_q       <= dest_field;
                        write_q        <= dec_write;
                        jump_q         <= dec_jump;
                        beq_q          <= dec_beq;
                        illegal_pend_q <= dec_illegal;
                        state_q        <= StExec;
                    end
                end
                StExec: begin
                    done_q          <= 1'b1;
                    branch_taken_q  <= jump_q | (beq_q & bus.alu_zero);
                    branch_offset_q <= offset_q;
                    illegal_q       <= illegal_pend_q;
                    state_q         <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Write-back lands on the EXEC edge; the regfile gives reset priority over it.
    logic wr_en;
    assign wr_en = (state_q == StExec) && write_q;

    alu_issue_regfile #(
        .RegCount  (RegCount),
        .DataWidth (DataWidth)
    ) u_regfile (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rd_addr1_i (rd_addr1),
        .rd_data1_o (rd_data1),
        .rd_addr2_i (rd_addr2),
        .rd_data2_o (rd_data2),
`ifdef ALU_ISSUE_DBG_EN
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o),
`endif
        .we_i       (wr_en),
        .waddr_i    (dest_q),
        .wdata_i    (bus.alu_result)
    );

    assign bus.instr_ready   = (state_q == StIdle);
    assign bus.alu_data1     = data1_q;
    assign bus.alu_data2     = data2_q;
    assign bus.alu_select    = sel_q;
    assign bus.done          = done_q;
    assign bus.branch_taken  = branch_taken_q;
    assign bus.branch_offset = branch_offset_q;
    assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed vector table, corner sequences, random run.
// Exercises the debug port as well when ALU_ISSUE_DBG_EN is defined.
module tb_alu_issue_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_total = 0;
    int n_pass  = 0;

    // Golden register contents, updated from the instruction semantics.
    int unsigned model [8];

    alu_issue_if bus ();

    alu_issue_unit dut (
        .clk_i      (clk),
        .reset_i    (reset),
`ifdef ALU_ISSUE_DBG_EN
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
`endif
        .bus        (bus)
    );

`ifndef ALU_ISSUE_DBG_EN
    assign dbg_data = 8'h00;
`endif

    always #5 clk = ~clk;

    // Behavioural 8-bit ALU driven by the unit's operands.
    logic [7:0] alu_sum;
    assign alu_sum = bus.alu_data1 + bus.alu_data2;
    always_comb begin
        bus.alu_result = 8'h00;
        case (bus.alu_select)
            3'b000:  bus.alu_result = bus.alu_data2;
            3'b001:  bus.alu_result = alu_sum;
            3'b010:  bus.alu_result = bus.alu_data1 & bus.alu_data2;
            3'b011:  bus.alu_result = bus.alu_data1 | bus.alu_data2;
            default: bus.alu_result = 8'h00;
        endcase
    end
    assign bus.alu_zero = (alu_sum == 8'h00);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] dst,
                                        input logic [7:0] s1, input logic [7:0] s2);
        return {op, dst, s1, s2};
    endfunction

    // Issue one instruction, check operands and retire against the model, update the model.
    task automatic issue(input logic [31:0] ins, input string tag,
                         output logic [7:0] o_d1, output logic [7:0] o_d2,
                         output logic [2:0] o_sel, output logic o_taken,
                         output logic o_illegal);
        int unsigned op, dst, a, b, imm, e_d1, e_d2, e_sel, res;
        bit wr, taken, ill;
        int n;
        op  = ins[31:24];
        dst = ins[18:16];
        imm = ins[7:0];
        a   = model[ins[10:8]];
        b   = model[ins[2:0]];
        e_d1 = 0; e_d2 = 0; e_sel = 0; res = 0; wr = 0; taken = 0; ill = 0;
        case (op)
            0: begin e_d2 = imm; res = imm; wr = 1; end
            1: begin e_d2 = b; res = b; wr = 1; end
            2: begin e_d1 = a; e_d2 = b; e_sel = 1; res = (a + b) % 256; wr = 1; end
            3: begin e_d1 = a; e_d2 = (256 - b) % 256; e_sel = 1; res = (a + 256 - b) % 256; wr = 1; end
            4: begin e_d1 = a; e_d2 = b; e_sel = 2; res = a & b; wr = 1; end
            5: begin e_d1 = a; e_d2 = b; e_sel = 3; res = a | b; wr = 1; end
            6: taken = 1;
            7: begin e_d1 = a; e_d2 = (256 - b) % 256; e_sel = 1; taken = (a == b); end
            default: ill = 1;
        endcase

        n = 0;
        while (!bus.instr_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready_wait"}, bus.instr_ready, 1);
        bus.instruction = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        o_d1 = bus.alu_data1;
        o_d2 = bus.alu_data2;
        o_sel = bus.alu_select;
        check({tag, " data1"}, bus.alu_data1, e_d1);
        check({tag, " data2"}, bus.alu_data2, e_d2);
        check({tag, " select"}, bus.alu_select, e_sel);
        check({tag, " ready_exec"}, bus.instr_ready, 0);
        check({tag, " done_low_exec"}, bus.done, 0);

        @(posedge clk); #1;
        o_taken = bus.branch_taken;
        o_illegal = bus.illegal;
        check({tag, " done"}, bus.done, 1);
        check({tag, " taken"}, bus.branch_taken, taken);
        check({tag, " illegal"}, bus.illegal, ill);
        check({tag, " offset"}, bus.branch_offset, ins[23:16]);
        check({tag, " ready_retire"}, bus.instr_ready, 1);
        if (wr) model[dst] = res;
`ifdef ALU_ISSUE_DBG_EN
        dbg_addr = ins[18:16];
        #1;
        check({tag, " dbg_data"}, dbg_data, model[dst]);
`endif
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [2:0]  sel;
        logic        taken;
        logic        ill;
    } vec_t;

    localparam int NumVec = 28;
    vec_t tbl [NumVec];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [7:0] d1, d2;
        logic [2:0] sel;
        logic taken, ill;
        int acc, dones;
        bit ready_before;
        logic [31:0] r;

        tbl[0]  = '{32'h00_01_00_05, 8'h00, 8'h05, 3'd0, 1'b0, 1'b0}; // loadi r1,05
        tbl[1]  = '{32'h00_02_00_03, 8'h00, 8'h03, 3'd0, 1'b0, 1'b0}; // loadi r2,03
        tbl[2]  = '{32'h02_03_01_02, 8'h05, 8'h03, 3'd1, 1'b0, 1'b0}; // add r3,r1,r2
        tbl[3]  = '{32'h03_04_01_02, 8'h05, 8'hFD, 3'd1, 1'b0, 1'b0}; // sub r4,r1,r2
        tbl[4]  = '{32'h03_05_02_01, 8'h03, 8'hFB, 3'd1, 1'b0, 1'b0}; // sub r5,r2,r1
        tbl[5]  = '{32'h00_06_00_D5, 8'h00, 8'hD5, 3'd0, 1'b0, 1'b0}; // loadi r6,D5
        tbl[6]  = '{32'h00_07_00_EA, 8'h00, 8'hEA, 3'd0, 1'b0, 1'b0}; // loadi r7,EA
        tbl[7]  = '{32'h04_00_06_07, 8'hD5, 8'hEA, 3'd2, 1'b0, 1'b0}; // and r0,r6,r7
        tbl[8]  = '{32'h07_00_00_00, 8'hC0, 8'h40, 3'd1, 1'b1, 1'b0}; // beq r0,r0 (r0=C0)
        tbl[9]  = '{32'h05_00_06_07, 8'hD5, 8'hEA, 3'd3, 1'b0, 1'b0}; // or r0,r6,r7
        tbl[10] = '{32'h07_00_00_00, 8'hFF, 8'h01, 3'd1, 1'b1, 1'b0}; // beq r0,r0 (r0=FF)
        tbl[11] = '{32'h07_00_03_03, 8'h08, 8'hF8, 3'd1, 1'b1, 1'b0}; // r3=08
        tbl[12] = '{32'h07_00_04_04, 8'h02, 8'hFE, 3'd1, 1'b1, 1'b0}; // r4=02
        tbl[13] = '{32'h07_00_05_05, 8'hFE, 8'h02, 3'd1, 1'b1, 1'b0}; // r5=FE
        tbl[14] = '{32'h07_FC_01_01, 8'h05, 8'hFB, 3'd1, 1'b1, 1'b0}; // beq r1,r1,FC
        tbl[15] = '{32'h07_00_01_02, 8'h05, 8'hFD, 3'd1, 1'b0, 1'b0}; // beq r1,r2 not taken
        tbl[16] = '{32'h06_10_00_00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0}; // j 0x10
        tbl[17] = '{32'h09_03_01_02, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1}; // illegal 0x09
        tbl[18] = '{32'h07_00_03_03, 8'h08, 8'hF8, 3'd1, 1'b1, 1'b0}; // r3 untouched
        tbl[19] = '{32'h01_03_00_05, 8'h00, 8'hFE, 3'd0, 1'b0, 1'b0}; // mov r3,r5
        tbl[20] = '{32'h00_02_00_80, 8'h00, 8'h80, 3'd0, 1'b0, 1'b0}; // loadi r2,80
        tbl[21] = '{32'h03_04_01_02, 8'h05, 8'h80, 3'd1, 1'b0, 1'b0}; // -0x80 == 0x80
        tbl[22] = '{32'h07_00_04_04, 8'h85, 8'h7B, 3'd1, 1'b1, 1'b0}; // r4=85
        tbl[23] = '{32'h02_01_01_01, 8'h05, 8'h05, 3'd1, 1'b0, 1'b0}; // add r1,r1,r1
        tbl[24] = '{32'h07_00_01_01, 8'h0A, 8'hF6, 3'd1, 1'b1, 1'b0}; // r1=0A
        tbl[25] = '{32'h07_00_03_03, 8'hFE, 8'h02, 3'd1, 1'b1, 1'b0}; // r3=FE
        tbl[26] = '{32'h00_0F_00_33, 8'h00, 8'h33, 3'd0, 1'b0, 1'b0}; // dest 0x0F -> r7
        tbl[27] = '{32'h07_00_17_0F, 8'h33, 8'hCD, 3'd1, 1'b1, 1'b0}; // srcs 0x17,0x0F -> r7

        for (int i = 0; i < 8; i++) model[i] = 0;
        bus.instr_valid = 1'b0;
        bus.instruction = 32'h0;
        dbg_addr = 3'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("reset ready", bus.instr_ready, 1);
        check("reset done", bus.done, 0);
        check("reset taken", bus.branch_taken, 0);
        check("reset illegal", bus.illegal, 0);
        check("reset offset", bus.branch_offset, 0);
        check("reset data1", bus.alu_data1, 0);
        check("reset data2", bus.alu_data2, 0);
        check("reset select", bus.alu_select, 0);

        for (int i = 0; i < NumVec; i++) begin
            issue(tbl[i].ins, $sformatf("vec%0d", i), d1, d2, sel, taken, ill);
            check($sformatf("vec%0d tbl_data1", i), d1, tbl[i].d1);
            check($sformatf("vec%0d tbl_data2", i), d2, tbl[i].d2);
            check($sformatf("vec%0d tbl_select", i), sel, tbl[i].sel);
            check($sformatf("vec%0d tbl_taken", i), taken, tbl[i].taken);
            check($sformatf("vec%0d tbl_illegal", i), ill, tbl[i].ill);
        end

        // instr_valid held across four edges with one add: accepted at the 1st and 3rd.
        bus.instruction = enc(8'h02, 8'h06, 8'h06, 8'h01);
        bus.instr_valid = 1'b1;
        acc = 0;
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            ready_before = bus.instr_ready;
            @(posedge clk); #1;
            if (ready_before) begin
                acc++;
                model[6] = (model[6] + model[1]) % 256;
                check($sformatf("hold ready_exec%0d", c), bus.instr_ready, 0);
            end
            if (bus.done) dones++;
        end
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        if (bus.done) dones++;
        check("hold acceptances", acc, 2);
        check("hold dones", dones, 2);
        check("hold ready_after", bus.instr_ready, 1);
        issue(enc(8'h07, 8'h00, 8'h06, 8'h06), "hold probe r6", d1, d2, sel, taken, ill);

        // Reset while add r3 is in EXEC: aborted, no DONE, register file cleared.
        bus.instruction = enc(8'h02, 8'h03, 8'h01, 8'h02);
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        check("abort in_exec", bus.instr_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort done", bus.done, 0);
        check("abort ready", bus.instr_ready, 1);
        check("abort data1", bus.alu_data1, 0);
        @(posedge clk); #1;
        check("abort done_later", bus.done, 0);
        for (int i = 0; i < 8; i++) model[i] = 0;
        for (int i = 0; i < 8; i++) begin
            issue(enc(8'h07, 8'h00, 8'(i), 8'(i)), $sformatf("abort probe r%0d", i),
                  d1, d2, sel, taken, ill);
        end

        // Randomised stream, including illegal opcodes and idle gaps.
        for (int k = 0; k < 80; k++) begin
            r = $urandom();
            issue({8'($urandom_range(0, 9)), r[23:0]}, $sformatf("rand%0d", k),
                  d1, d2, sel, taken, ill);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                check($sformatf("rand%0d done_drop", k), bus.done, 0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            issue(enc(8'h07, 8'h00, 8'(i), 8'(i)), $sformatf("final probe r%0d", i),
                  d1, d2, sel, taken, ill);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
